// File: rtl/plot_fb_writer.sv
// Plot-request receiver: FIFO-buffered pixel writes into a 160x120 framebuffer plus a full-screen clear.
// Optional feature macro: PLOT_FB_CLIP_COUNT_EN (saturating count of clipped requests on drop_count).
module plot_fb_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_x,
  input  logic [6:0]  in_y,
  input  logic [8:0]  in_colour,
  input  logic        in_plot,
  output logic        in_ready,
  input  logic        clear_go,
  input  logic [8:0]  clear_colour,
  output logic        busy,
  output logic [14:0] mem_address,
  output logic [8:0]  mem_data,
  output logic        mem_wren,
  output logic [7:0]  drop_count
);

  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [14:0] LAST_ADDR = 15'(SCREEN_W * SCREEN_H - 1);
  localparam logic [7:0]  X_LIM     = 8'(SCREEN_W);
  localparam logic [6:0]  Y_LIM     = 7'(SCREEN_H);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [23:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;
  logic [14:0]   r_clr_cnt, w_clr_cnt_nxt;
  logic [8:0]    r_clr_colour, w_clr_colour_nxt;
  logic          w_full, w_empty, w_push, w_pop, w_in_range;
  logic [7:0]    w_hx;
  logic [6:0]    w_hy;
  logic [8:0]    w_hc;
  logic [14:0]   w_pix_addr;
  logic          w_wren_nxt, w_busy_nxt;
  logic [14:0]   w_addr_nxt;
  logic [8:0]    w_data_nxt;

  assign w_full   = (r_count == (PW+1)'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_plot && !w_full;
  // clear_go takes priority over a pending pop; the entry stays queued
  assign w_pop    = (r_state == S_IDLE) && !clear_go && !w_empty;

  assign {w_hx, w_hy, w_hc} = r_fifo[r_rd_ptr];
  assign w_in_range = (w_hx < X_LIM) && (w_hy < Y_LIM);
  // y*160 + x as shifts: (y<<7) + (y<<5) + x
  assign w_pix_addr = {1'b0, w_hy, 7'd0} + {3'd0, w_hy, 5'd0} + {7'd0, w_hx};

  // FIFO payload storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {in_x, in_y, in_colour};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  // State register plus registered outputs and clear bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= 15'd0;
      r_clr_colour <= 9'd0;
      mem_wren     <= 1'b0;
      mem_address  <= 15'd0;
      mem_data     <= 9'd0;
      busy         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_clr_colour <= w_clr_colour_nxt;
      mem_wren     <= w_wren_nxt;
      mem_address  <= w_addr_nxt;
      mem_data     <= w_data_nxt;
      busy         <= w_busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (clear_go) w_state_nxt = S_CLEAR;
        else          w_state_nxt = S_IDLE;
      end
      S_CLEAR: begin
        if (r_clr_cnt == LAST_ADDR) w_state_nxt = S_IDLE;
        else                        w_state_nxt = S_CLEAR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered write port, busy and clear counter
  always_comb begin
    w_wren_nxt       = 1'b0;
    w_addr_nxt       = mem_address;
    w_data_nxt       = mem_data;
    w_busy_nxt       = 1'b0;
    w_clr_cnt_nxt    = r_clr_cnt;
    w_clr_colour_nxt = r_clr_colour;
    case (r_state)
      S_IDLE: begin
        if (clear_go) begin
          w_busy_nxt       = 1'b1;
          w_clr_cnt_nxt    = 15'd0;
          w_clr_colour_nxt = clear_colour;
        end else if (w_pop && w_in_range) begin
          w_wren_nxt = 1'b1;
          w_addr_nxt = w_pix_addr;
          w_data_nxt = w_hc;
        end else begin
          w_wren_nxt = 1'b0;
        end
      end
      S_CLEAR: begin
        w_wren_nxt = 1'b1;
        w_addr_nxt = r_clr_cnt;
        w_data_nxt = r_clr_colour;
        if (r_clr_cnt == LAST_ADDR) begin
          w_busy_nxt    = 1'b0;
          w_clr_cnt_nxt = 15'd0;
        end else begin
          w_busy_nxt    = 1'b1;
          w_clr_cnt_nxt = r_clr_cnt + 15'd1;
        end
      end
      default: begin
        w_wren_nxt = 1'b0;
      end
    endcase
  end

`ifdef PLOT_FB_CLIP_COUNT_EN
  logic [7:0] r_drop_count;
  logic       w_drop_inc;

  assign w_drop_inc = w_pop && !w_in_range;
  assign drop_count = r_drop_count;

  // Saturating count of clipped (off-screen) requests
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= 8'd0;
    end else if (w_drop_inc && (r_drop_count != 8'hFF)) begin
      r_drop_count <= r_drop_count + 8'd1;
    end
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_plot_fb_writer.sv
// Self-checking bench for plot_fb_writer: randomized and directed plots against a queue-based model.
module tb_plot_fb_writer;
  localparam int W = 160;
  localparam int H = 120;
  localparam int D = 4;
  localparam int NPIX = W * H;
`ifdef PLOT_FB_CLIP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  in_x = 8'd0;
  logic [6:0]  in_y = 7'd0;
  logic [8:0]  in_colour = 9'd0;
  logic        in_plot = 1'b0;
  logic        in_ready;
  logic        clear_go = 1'b0;
  logic [8:0]  clear_colour = 9'd0;
  logic        busy;
  logic [14:0] mem_address;
  logic [8:0]  mem_data;
  logic        mem_wren;
  logic [7:0]  drop_count;

  plot_fb_writer dut (
    .clk(clk), .reset(reset), .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
    .in_plot(in_plot), .in_ready(in_ready), .clear_go(clear_go), .clear_colour(clear_colour),
    .busy(busy), .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int log_addr[$], log_data[$], log_cyc[$];
  int exp_addr[$], exp_data[$];
  int drops = 0;

  always @(posedge clk) cyc++;

  // write monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      log_addr.push_back(int'(mem_address));
      log_data.push_back(int'(mem_data));
      log_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt++;
  end

  function automatic int exp_drop();
    if (!CNT_EN) return 0;
    return (drops > 255) ? 255 : drops;
  endfunction

  task automatic model_plot(input int x, input int y, input int c);
    if (x < W && y < H) begin
      exp_addr.push_back(y * W + x);
      exp_data.push_back(c);
    end else begin
      drops++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_plot = 1'b0; clear_go = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    exp_addr.delete(); exp_data.delete();
    drops = 0; busy_cnt = 0;
  endtask

  // drive one request for one cycle; called at a negedge
  task automatic drive_plot(input int x, input int y, input int c, output bit acc);
    in_x = x[7:0]; in_y = y[6:0]; in_colour = c[8:0]; in_plot = 1'b1;
    acc = in_ready;
    @(negedge clk);
    in_plot = 1'b0;
    if (acc) model_plot(x, y, c);
  endtask

  task automatic compare_log(input string name, input int start);
    int bad;
    bad = -1;
    checks++;
    if (log_addr.size() - start !== exp_addr.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d writes, expected %0d", name, log_addr.size() - start, exp_addr.size());
    end else begin
      checks++;
      for (int i = 0; i < exp_addr.size(); i++)
        if (bad < 0 && (log_addr[start+i] !== exp_addr[i] || log_data[start+i] !== exp_data[i])) bad = i;
      if (bad >= 0) begin
        failures++;
        $display("FAIL %s_write[%0d]: got addr=%0d data=%0h, expected addr=%0d data=%0h", name, bad,
                 log_addr[start+bad], log_data[start+bad], exp_addr[bad], exp_data[bad]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({mem_wren, busy, in_ready} !== 3'b001) begin
      failures++; $display("FAIL reset_flags: got wren/busy/ready=%b, expected 001", {mem_wren, busy, in_ready});
    end
    checks++;
    if (mem_address !== 15'd0 || mem_data !== 9'd0) begin
      failures++; $display("FAIL reset_mem: got addr=%0d data=%0h, expected 0/0", mem_address, mem_data);
    end
    checks++;
    if (drop_count !== 8'd0) begin
      failures++; $display("FAIL reset_drop: got %0d, expected 0", drop_count);
    end
  endtask

  task automatic test_single();
    bit acc;
    do_reset();
    drive_plot(5, 3, 9'b101_010_000, acc);
    checks++;
    if (mem_wren !== 1'b0) begin
      failures++; $display("FAIL single_early: got wren=%b one edge after accept, expected 0", mem_wren);
    end
    @(negedge clk);
    checks++;
    if (mem_wren !== 1'b1 || mem_address !== 15'd485 || mem_data !== 9'b101_010_000) begin
      failures++; $display("FAIL single_write: got wren=%b addr=%0d data=%b, expected 1/485/101010000",
                           mem_wren, mem_address, mem_data);
    end
    repeat (4) @(negedge clk);
    compare_log("single", 0);
  endtask

  task automatic test_tile();
    bit acc;
    int not_ready;
    int gaps;
    not_ready = 0; gaps = 0;
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        drive_plot(8 + c, 8 + r, $urandom_range(0, 511), acc);
        if (!acc) not_ready++;
      end
    repeat (4) @(negedge clk);
    checks++;
    if (not_ready !== 0) begin
      failures++; $display("FAIL tile_ready: got %0d stalled cycles, expected 0", not_ready);
    end
    compare_log("tile", 0);
    for (int i = 1; i < log_cyc.size(); i++) if (log_cyc[i] - log_cyc[i-1] != 1) gaps++;
    checks++;
    if (gaps !== 0) begin
      failures++; $display("FAIL tile_consecutive: got %0d gaps, expected 0", gaps);
    end
  endtask

  task automatic test_clip();
    bit acc;
    do_reset();
    drive_plot(160, 0, 9'h055, acc);
    drive_plot(0, 120, 9'h0AA, acc);
    drive_plot(159, 119, 9'h1C7, acc);
    repeat (4) @(negedge clk);
    compare_log("clip", 0);
    checks++;
    if (int'(drop_count) !== exp_drop()) begin
      failures++; $display("FAIL clip_drop: got %0d, expected %0d", drop_count, exp_drop());
    end
  endtask

  task automatic test_random();
    bit acc;
    int stalls;
    stalls = 0;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        drive_plot($urandom_range(0, 199), $urandom_range(0, 127), $urandom_range(0, 511), acc);
        if (!acc) stalls++;
      end else begin
        @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    compare_log("random", 0);
    checks++;
    if (int'(drop_count) !== exp_drop()) begin
      failures++; $display("FAIL random_drop: got %0d, expected %0d", drop_count, exp_drop());
    end
    checks++;
    if (stalls !== 0) begin
      failures++; $display("FAIL random_ready: got %0d stalls, expected 0", stalls);
    end
  endtask

  task automatic test_clear();
    bit acc;
    int accepted;
    int guard;
    int bad;
    accepted = 0; guard = 0; bad = -1;
    do_reset();
    clear_go = 1'b1; clear_colour = 9'd0;
    drive_plot(10, 20, 9'h111, acc);
    clear_go = 1'b0;
    if (acc) accepted++;
    for (int k = 0; k < 5; k++) begin
      drive_plot($urandom_range(0, 159), $urandom_range(0, 119), $urandom_range(0, 511), acc);
      if (acc) accepted++;
    end
    checks++;
    if (accepted !== D || in_ready !== 1'b0) begin
      failures++; $display("FAIL clear_fifo_full: got accepted=%0d ready=%b, expected %0d/0", accepted, in_ready, D);
    end
    repeat (100) @(negedge clk);
    clear_colour = 9'h1FF; clear_go = 1'b1;
    @(negedge clk);
    clear_go = 1'b0;
    while (busy === 1'b1 && guard < 25000) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (guard >= 25000) begin
      failures++; $display("FAIL clear_timeout: busy still %b after %0d cycles, expected 0", busy, guard);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (busy_cnt !== NPIX) begin
      failures++; $display("FAIL clear_busy_len: got %0d, expected %0d", busy_cnt, NPIX);
    end
    checks++;
    if (log_addr.size() < NPIX) begin
      failures++; $display("FAIL clear_writes: got %0d, expected at least %0d", log_addr.size(), NPIX);
    end else begin
      for (int i = 0; i < NPIX; i++)
        if (bad < 0 && (log_addr[i] !== i || log_data[i] !== 0 || log_cyc[i] - log_cyc[0] != i)) bad = i;
      if (bad >= 0) begin
        failures++; $display("FAIL clear_seq[%0d]: got addr=%0d data=%0h, expected addr=%0d data=0",
                             bad, log_addr[bad], log_data[bad], bad);
      end
      compare_log("post_clear", NPIX);
      if (log_cyc.size() > NPIX) begin
        checks++;
        if (log_cyc[NPIX] - log_cyc[NPIX-1] !== 1) begin
          failures++; $display("FAIL post_clear_gap: got %0d cycles, expected 1", log_cyc[NPIX] - log_cyc[NPIX-1]);
        end
      end
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL clear_ready_after: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_reset_mid_clear();
    bit acc;
    int guard;
    guard = 0;
    do_reset();
    clear_go = 1'b1; clear_colour = 9'h0AA;
    drive_plot(1, 1, 9'h0F0, acc);
    clear_go = 1'b0;
    for (int k = 0; k < 4; k++) drive_plot(k + 2, 2, 9'h00F, acc);
    while (log_addr.size() < 5001 && guard < 8000) begin
      @(negedge clk); guard++;
    end
    checks++;
    if (guard >= 8000 || in_ready !== 1'b0) begin
      failures++; $display("FAIL midclear_setup: got writes=%0d ready=%b, expected 5001/0", log_addr.size(), in_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    log_addr.delete(); log_data.delete(); log_cyc.delete();
    checks++;
    if ({mem_wren, busy, in_ready} !== 3'b001 || drop_count !== 8'd0) begin
      failures++; $display("FAIL midclear_reset: got wren/busy/ready=%b drop=%0d, expected 001/0",
                           {mem_wren, busy, in_ready}, drop_count);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (log_addr.size() !== 0) begin
      failures++; $display("FAIL midclear_stale: got %0d writes, expected 0", log_addr.size());
    end
  endtask

  task automatic test_saturate();
    bit acc;
    do_reset();
    for (int i = 0; i < 300; i++) drive_plot(200 + (i % 50), $urandom_range(0, 127), 9'h123, acc);
    repeat (4) @(negedge clk);
    checks++;
    if (int'(drop_count) !== exp_drop()) begin
      failures++; $display("FAIL saturate_drop: got %0d, expected %0d", drop_count, exp_drop());
    end
    checks++;
    if (log_addr.size() !== 0) begin
      failures++; $display("FAIL saturate_writes: got %0d, expected 0", log_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tile();
    test_clip();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
